lock_fsm_multi: RTL and testbench

Parametrised keypad lock controller: multi-digit code entry over three debounced buttons, with configurable code length and digit width, auto-relock, entry timeout, and a fail counter that forces a timed lockout after repeated wrong codes. Drives the status LEDs, buzzer and solenoid relay. It is the next-generation replacement for the fixed 3-bit lock FSM, and runs directly on `hw_clk` using an internal tick prescaler.

---
 rtl/lock_pkg.sv | 23 ++
 rtl/lock_tick_gen.sv | 23 ++
 rtl/lock_fsm_multi.sv | 167 ++++++++++++++++
 tb/tb_lock_fsm_multi.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock family: state encoding, LED/relay polarity.
// Pure declarations; no logic, no latency.
package lock_pkg;

    typedef enum logic [2:0] {
        S_LOCKED   = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_ERROR    = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    localparam logic LED_ON       = 1'b0;
    localparam logic LED_OFF      = 1'b1;
    localparam logic RELAY_ACTIVE = 1'b0;
    localparam logic RELAY_IDLE   = 1'b1;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, decoded from the registered count.
// No inputs besides reset, so no backpressure.
module lock_tick_gen #(
    parameter int TICK_DIV = 2_000_000
) (
    input  logic hw_clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge hw_clk) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/lock_fsm_multi.sv
// Multi-digit keypad lock: edge-detected buttons drive the FSM; a press acts on the edge it registers.
// Outputs are a combinational decode of registered state; buttons are never stalled, excess presses are dropped.
module lock_fsm_multi
    import lock_pkg::*;
#(
    parameter int                          DIGITS         = 4,
    parameter int                          DIGIT_W        = 2,
    parameter logic [DIGITS*DIGIT_W-1:0]   PASSWORD       = 8'h9C,
    parameter int                          TICK_DIV       = 2_000_000,
    parameter int                          UNLOCK_TICKS   = 100,
    parameter int                          ENTRY_TIMEOUT  = 300,
    parameter int                          MAX_FAILS      = 3,
    parameter int                          LOCKOUT_TICKS  = 600,
    parameter int                          BUZZ_OK_TICKS  = 10,
    parameter int                          BUZZ_ERR_TICKS = 25
) (
    input  logic                                       hw_clk,
    input  logic                                       reset,
    input  logic                                       btn_inc,
    input  logic                                       btn_next,
    input  logic                                       btn_enter,
    output logic                                       led_red,
    output logic                                       led_green,
    output logic                                       led_blue,
    output logic                                       buzzer,
    output logic                                       relay_ctrl,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx,
    output logic [DIGIT_W-1:0]                         digit_val,
    output logic [$clog2(MAX_FAILS+1)-1:0]             fail_count
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int TMR_W  = $clog2(max_i(max_i(UNLOCK_TICKS, ENTRY_TIMEOUT), LOCKOUT_TICKS) + 1);
    localparam int BUZZ_W = $clog2(max_i(BUZZ_OK_TICKS, BUZZ_ERR_TICKS) + 1);

    state_t              state, state_nxt;
    logic                inc_d, next_d, enter_d;
    logic [CODE_W-1:0]   code, code_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [FAIL_W-1:0]   fail, fail_nxt;
    logic [TMR_W-1:0]    tmr;
    logic [BUZZ_W-1:0]   buzz;
    logic                tick;

    lock_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .hw_clk (hw_clk),
        .reset  (reset),
        .tick   (tick)
    );

    logic p_inc, p_next, p_enter, any_press, do_next, do_inc, code_ok, timed;

    assign p_inc     = btn_inc   & ~inc_d;
    assign p_next    = btn_next  & ~next_d;
    assign p_enter   = btn_enter & ~enter_d;
    assign any_press = p_inc | p_next | p_enter;
    assign do_next   = p_next & ~p_enter;
    assign do_inc    = p_inc & ~p_next & ~p_enter;
    assign code_ok   = (code == PASSWORD);
    assign timed     = (state == S_ENTRY) || (state == S_UNLOCKED) || (state == S_LOCKOUT);

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        idx_nxt   = idx;
        fail_nxt  = fail;
        case (state)
            S_LOCKED: if (p_enter) state_nxt = S_ENTRY;
            S_ENTRY: begin
                if (p_enter) begin
                    state_nxt = S_CHECK;
                end else if (do_next) begin
                    if (idx != IDX_W'(DIGITS - 1)) idx_nxt = idx + 1'b1;
                end else if (do_inc) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IDX_W'(i))
                            code_nxt[i*DIGIT_W +: DIGIT_W] = code[i*DIGIT_W +: DIGIT_W] + 1'b1;
                    end
                end else if (tmr == TMR_W'(ENTRY_TIMEOUT)) begin
                    state_nxt = S_LOCKED;
                end
            end
            S_CHECK: begin
                if (code_ok) begin
                    state_nxt = S_UNLOCKED;
                    fail_nxt  = '0;
                end else begin
                    fail_nxt  = fail + 1'b1;
                    state_nxt = (fail_nxt == FAIL_W'(MAX_FAILS)) ? S_LOCKOUT : S_ERROR;
                end
            end
            S_UNLOCKED: if (p_enter || tmr == TMR_W'(UNLOCK_TICKS)) state_nxt = S_LOCKED;
            S_ERROR:    if (p_enter) state_nxt = S_LOCKED;
            S_LOCKOUT: begin
                if (tmr == TMR_W'(LOCKOUT_TICKS)) begin
                    state_nxt = S_LOCKED;
                    fail_nxt  = '0;
                end
            end
            default: state_nxt = S_LOCKED;
        endcase
        // The code only lives while in ENTRY/CHECK; a fresh ENTRY always starts blank.
        if ((state_nxt != S_ENTRY && state_nxt != S_CHECK) ||
            (state != S_ENTRY && state_nxt == S_ENTRY)) begin
            code_nxt = '0;
            idx_nxt  = '0;
        end
    end

    always_ff @(posedge hw_clk) begin
        if (reset) begin
            state   <= S_LOCKED;
            inc_d   <= 1'b0;
            next_d  <= 1'b0;
            enter_d <= 1'b0;
            code    <= '0;
            idx     <= '0;
            fail    <= '0;
            tmr     <= '0;
            buzz    <= '0;
        end else begin
            state   <= state_nxt;
            inc_d   <= btn_inc;
            next_d  <= btn_next;
            enter_d <= btn_enter;
            code    <= code_nxt;
            idx     <= idx_nxt;
            fail    <= fail_nxt;
            if (state_nxt != state)                 tmr <= '0;
            else if (state == S_ENTRY && any_press) tmr <= '0;
            else if (tick && timed)                 tmr <= tmr + 1'b1;
            if (state == S_CHECK)
                buzz <= code_ok ? BUZZ_W'(BUZZ_OK_TICKS) : BUZZ_W'(BUZZ_ERR_TICKS);
            else if (tick && buzz != '0)
                buzz <= buzz - 1'b1;
        end
    end

    always_comb begin
        led_red   = LED_OFF;
        led_green = LED_OFF;
        led_blue  = LED_OFF;
        case (state)
            S_LOCKED:   led_red   = LED_ON;
            S_ENTRY:    led_blue  = LED_ON;
            S_UNLOCKED: led_green = LED_ON;
            S_ERROR: begin
                led_red  = LED_ON;
                led_blue = LED_ON;
            end
            S_LOCKOUT:  led_red   = tmr[0] ? LED_OFF : LED_ON;
            default: ;
        endcase
        digit_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) digit_val = code[i*DIGIT_W +: DIGIT_W];
        end
    end

    assign buzzer     = (buzz != '0);
    assign relay_ctrl = (state == S_UNLOCKED) ? RELAY_ACTIVE : RELAY_IDLE;
    assign digit_idx  = idx;
    assign fail_count = fail;

endmodule

// File: tb/tb_lock_fsm_multi.sv
// Directed and random stimulus for lock_fsm_multi, checked every cycle against a behavioural model.
module tb_lock_fsm_multi;

    localparam int DIGITS = 4, DIGIT_W = 2, TICK_DIV = 4;
    localparam int UNLOCK_T = 5, ENTRY_TO = 20, MAX_F = 3, LOCKOUT_T = 8, BOK = 2, BERR = 4;
    localparam int PASS = 'h9C;
    localparam int M_LK = 0, M_EN = 1, M_CK = 2, M_UN = 3, M_ER = 4, M_LO = 5;

    logic       hw_clk = 1'b0;
    logic       reset = 1'b1, btn_inc = 1'b0, btn_next = 1'b0, btn_enter = 1'b0;
    logic       led_red, led_green, led_blue, buzzer, relay_ctrl;
    logic [1:0] digit_idx, digit_val, fail_count;

    int n_assert = 0, n_fail = 0;

    int m_mode, m_idx, m_fail, m_tmr, m_buzz, m_pre;
    int m_code[DIGITS];
    bit m_pi, m_pn, m_pe;

    lock_fsm_multi #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .PASSWORD(8'h9C), .TICK_DIV(TICK_DIV),
        .UNLOCK_TICKS(UNLOCK_T), .ENTRY_TIMEOUT(ENTRY_TO), .MAX_FAILS(MAX_F),
        .LOCKOUT_TICKS(LOCKOUT_T), .BUZZ_OK_TICKS(BOK), .BUZZ_ERR_TICKS(BERR)
    ) dut (
        .hw_clk(hw_clk), .reset(reset), .btn_inc(btn_inc), .btn_next(btn_next),
        .btn_enter(btn_enter), .led_red(led_red), .led_green(led_green), .led_blue(led_blue),
        .buzzer(buzzer), .relay_ctrl(relay_ctrl), .digit_idx(digit_idx),
        .digit_val(digit_val), .fail_count(fail_count)
    );

    always #5 hw_clk = ~hw_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Reference: one clock edge of the lock as described in words, with integer bookkeeping.
    task automatic model_edge(input bit r, input bit bi, input bit bn, input bit be);
        bit tick, pe, pn, pi, any;
        int nm, v;
        if (r) begin
            m_mode = M_LK; m_idx = 0; m_fail = 0; m_tmr = 0; m_buzz = 0; m_pre = 0;
            foreach (m_code[i]) m_code[i] = 0;
            m_pi = 0; m_pn = 0; m_pe = 0;
            return;
        end
        tick  = (m_pre == TICK_DIV - 1);
        m_pre = (m_pre + 1) % TICK_DIV;
        pe  = be && !m_pe;
        pn  = bn && !m_pn;
        pi  = bi && !m_pi;
        any = pe || pn || pi;
        m_pi = bi; m_pn = bn; m_pe = be;
        nm = m_mode;
        if (m_buzz > 0 && tick && m_mode != M_CK) m_buzz--;
        case (m_mode)
            M_LK: if (pe) nm = M_EN;
            M_EN: begin
                if (pe) nm = M_CK;
                else if (pn) m_idx = (m_idx < DIGITS - 1) ? m_idx + 1 : m_idx;
                else if (pi) m_code[m_idx] = (m_code[m_idx] + 1) % (1 << DIGIT_W);
                else if (m_tmr == ENTRY_TO) nm = M_LK;
            end
            M_CK: begin
                v = 0;
                for (int i = 0; i < DIGITS; i++) v += m_code[i] * (1 << (i * DIGIT_W));
                if (v == PASS) begin
                    nm = M_UN; m_fail = 0; m_buzz = BOK;
                end else begin
                    m_fail++; m_buzz = BERR;
                    nm = (m_fail == MAX_F) ? M_LO : M_ER;
                end
            end
            M_UN: if (pe || m_tmr == UNLOCK_T) nm = M_LK;
            M_ER: if (pe) nm = M_LK;
            M_LO: if (m_tmr == LOCKOUT_T) begin nm = M_LK; m_fail = 0; end
            default: nm = M_LK;
        endcase
        if (nm != m_mode) m_tmr = 0;
        else if (m_mode == M_EN && any) m_tmr = 0;
        else if (tick && (m_mode == M_EN || m_mode == M_UN || m_mode == M_LO)) m_tmr++;
        if (!(nm == M_EN || nm == M_CK) || (m_mode != M_EN && nm == M_EN)) begin
            foreach (m_code[i]) m_code[i] = 0;
            m_idx = 0;
        end
        m_mode = nm;
    endtask

    function automatic logic [10:0] model_out();
        logic r, g, b;
        r = 1; g = 1; b = 1;
        case (m_mode)
            M_LK: r = 0;
            M_EN: b = 0;
            M_UN: g = 0;
            M_ER: begin r = 0; b = 0; end
            M_LO: r = (m_tmr % 2 == 0) ? 1'b0 : 1'b1;
            default: ;
        endcase
        return {r, g, b, logic'(m_buzz > 0), logic'(m_mode != M_UN),
                2'(m_idx), 2'(m_code[m_idx]), 2'(m_fail)};
    endfunction

    task automatic step(input bit r, input bit bi, input bit bn, input bit be);
        reset = r; btn_inc = bi; btn_next = bn; btn_enter = be;
        @(posedge hw_clk);
        model_edge(r, bi, bn, be);
        @(negedge hw_clk);
        check("cycle", {21'd0, led_red, led_green, led_blue, buzzer, relay_ctrl,
                        digit_idx, digit_val, fail_count}, {21'd0, model_out()});
    endtask

    task automatic press(input bit bi, input bit bn, input bit be);
        step(0, bi, bn, be);
        step(0, 0, 0, 0);
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
        int d[4];
        d = '{d0, d1, d2, d3};
        press(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) press(0, 1, 0);
            repeat (d[i]) press(1, 0, 0);
        end
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset_leds", {led_red, led_green, led_blue}, 3'b011);
        check("reset_misc", {buzzer, relay_ctrl, digit_idx, digit_val, fail_count}, 8'b01_000000);

        // 1: correct code, then auto-relock
        enter_code(0, 3, 1, 2);
        check("pre_submit_relay", relay_ctrl, 1'b1);
        press(0, 0, 1);
        check("unlock_relay", relay_ctrl, 1'b0);
        check("unlock_buzz", buzzer, 1'b1);
        check("unlock_fail", fail_count, 2'd0);
        for (int i = 0; i < 60 && relay_ctrl !== 1'b1; i++) step(0, 0, 0, 0);
        check("relock_relay", relay_ctrl, 1'b1);
        check("relock_red", led_red, 1'b0);

        // 2: digit wrap, index saturation, wrong code
        press(0, 0, 1);
        repeat (5) press(1, 0, 0);
        check("wrap_val", digit_val, 2'd1);
        repeat (5) press(0, 1, 0);
        check("sat_idx", digit_idx, 2'd3);
        press(0, 0, 1);
        check("err_fail", fail_count, 2'd1);
        check("err_leds", {led_red, led_blue}, 2'b00);
        check("err_buzz", buzzer, 1'b1);
        for (int i = 0; i < 40 && buzzer !== 1'b0; i++) step(0, 0, 0, 0);
        check("err_buzz_end", buzzer, 1'b0);
        press(0, 0, 1);

        // 3: two more failures reach lockout
        for (int k = 0; k < 2; k++) begin
            press(0, 0, 1);
            press(0, 0, 1);
            if (k == 0) press(0, 0, 1);
        end
        check("lockout_fail", fail_count, 2'd3);
        press(0, 0, 1);
        check("lockout_ignore", fail_count, 2'd3);
        for (int i = 0; i < 100 && fail_count !== 2'd0; i++) step(0, 0, 0, 0);
        check("lockout_exit_fail", fail_count, 2'd0);
        check("lockout_exit_red", led_red, 1'b0);

        // 4: simultaneous presses
        press(0, 0, 1);
        press(1, 1, 0);
        check("simul_idx", digit_idx, 2'd1);
        check("simul_val", digit_val, 2'd0);
        press(1, 0, 1);
        check("simul_enter_fail", fail_count, 2'd1);
        press(0, 0, 1);

        // 5: entry timeout
        press(0, 0, 1);
        press(1, 0, 0);
        for (int i = 0; i < 150 && led_blue !== 1'b1; i++) step(0, 0, 0, 0);
        check("timeout_idx_val", {digit_idx, digit_val}, 4'd0);
        check("timeout_red", led_red, 1'b0);

        // 6: reset while unlocked with buzzer running
        enter_code(0, 3, 1, 2);
        press(0, 0, 1);
        check("pre_reset_buzz", buzzer, 1'b1);
        step(1, 0, 0, 0);
        check("rst_relay_buzz", {relay_ctrl, buzzer}, 2'b10);
        check("rst_fail_red", {fail_count, led_red}, 3'b000);
        step(0, 0, 0, 0);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
